mem_block_mover: RTL
====================

# mem_block_mover

Bus-initiator block that drives the data-memory port (rd/wr/addr/wdata/rdata, word-addressed, combinational read, write on the rising clock edge). On a start pulse it copies a block of `len` words from `src` to `dst`, one read cycle then one write cycle per word, and reports completion or a range error. It sits beside the CPU datapath and takes over the data-memory port while busy; the top level muxes its port with the CPU's on `busy`.

## Interface
- `RAM_SIZE`, 256, number of 32-bit words in the target memory; legal addresses 0..RAM_SIZE-1.
- `LEN_W`, 9, width of `len`; must hold RAM_SIZE.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `start`  in  1  request; sampled only in IDLE.
- `src`  in  32  source word address; latched on an accepted start.
- `dst`  in  32  destination word address; latched on an accepted start.
- `len`  in  LEN_W  word count; latched on an accepted start.
- `fill`  in  1  fill-mode select; used only with MOVER_FILL_EN.
- `pattern`  in  32  fill word; used only with MOVER_FILL_EN.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of every accepted request.
- `err`  out  1  high together with `done` when the request was rejected.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `mem_addr`  out  32  memory word address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, combinational from `mem_rd` and `mem_addr`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: all outputs 0. `start`=1 latches `src`/`dst`/`len`/`fill`/`pattern`, then:
  - `src+len > RAM_SIZE` or `dst+len > RAM_SIZE` (33-bit compare, no wrap): go to DONE with error flag set, no memory access.
  - `len`=0: go to DONE, `err`=0, no memory access.
  - otherwise: go to READ with index i=0.
- Direction: if `dst > src` and `dst < src+len`, copy descending (word len-1 first). Otherwise copy ascending. Overlapping copies therefore never read an already-overwritten word.
- READ: `mem_rd`=1, `mem_addr`=src+k, where k=i (ascending) or len-1-i (descending). `mem_rdata` is registered into the data buffer at the edge; next state is WRITE.
- WRITE: `mem_wr`=1, `mem_addr`=dst+k, `mem_wdata`=buffer. At the edge, i increments; next state is DONE if i was len-1, else READ.
- DONE: `done`=1, `err`=error flag, `busy`=1. Next state is IDLE unconditionally and the error flag clears.
- `start` outside IDLE is ignored; it is neither queued nor acknowledged.
- `mem_rd` and `mem_wr` are never high together. `mem_addr` and `mem_wdata` are 0 whenever their strobe is low.
- Reset mid-operation: return to IDLE asynchronously and drop all outputs to 0. No `done` is issued. Words already written stay written.

## Timing
- Reset values: `busy`, `done`, `err`, `mem_rd`, `mem_wr` are 0; `mem_addr` and `mem_wdata` are 0.
- `start` is accepted at edge T0. READ of the first word occurs in cycle T0+1, its WRITE in T0+2.
- `done` is high in cycle T0+2·len+1 for copy, T0+1 for `len`=0 or error. `busy` falls in the following cycle.
- Back-to-back: `start` may be accepted in the first IDLE cycle after DONE, so the minimum gap is one cycle.
- All outputs are decoded from registered state, counters and latched operands; none depend combinationally on the inputs.

## Configuration
- `MOVER_FILL_EN` defined: `fill`=1 on start skips READ entirely. Each WRITE cycle writes `pattern` to dst+i in ascending order and `src` is not range-checked. `done` arrives at T0+len+1.
- `MOVER_FILL_EN` undefined: `fill` and `pattern` are ignored and every request is a copy; the ports stay present for a fixed top-level wiring.

## Test plan
- Memory preset with words 10..13 = A0..A3; start src=10, dst=20, len=4 -> words 20..23 = A0..A3, alternating rd/wr over 8 cycles, `done` at T0+9, `err`=0.
- Overlap, words 0..3 = 1,2,3,4; start src=0, dst=2, len=4 -> words 2..5 = 1,2,3,4; first write address is 5 (descending order).
- start src=250, dst=0, len=7 (RAM_SIZE=256) -> `done`=`err`=1 at T0+1, no `mem_rd`/`mem_wr` pulse, memory unchanged.
- len=0 -> `done`=1, `err`=0 at T0+1, no memory access. A `start` pulse during a 4-word copy is ignored and produces exactly one `done`.
- Assert `reset` during the 3rd WRITE of a 4-word copy -> all outputs 0 immediately, no `done`, words dst..dst+1 written, dst+3 untouched. A fresh start afterwards completes normally.
- With `MOVER_FILL_EN`: fill=1, pattern=DEADBEEF, dst=100, len=3 -> words 100..102 = DEADBEEF, `mem_rd` never high, `done` at T0+4. Without the macro the same stimulus performs a copy.

Source files
------------

// File: rtl/mem_block_mover.sv
// mem_block_mover: copies (or, with MOVER_FILL_EN, fills) a block of words over the data-memory port.
//   clk, reset (async, active-high)
//   start, src, dst, len        request and operands, latched when accepted in IDLE
//   fill, pattern               fill-mode request and fill word (used only when MOVER_FILL_EN is defined)
//   busy, done, err             status: busy outside IDLE, one-cycle done pulse, err flags a rejected request
//   mem_rd, mem_wr, mem_addr, mem_wdata, mem_rdata   memory port (combinational read, write on clock edge)
module mem_block_mover #(
   parameter int RAM_SIZE = 256,
   parameter int LEN_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src,
   input  logic [31:0]      dst,
   input  logic [LEN_W-1:0] len,
   input  logic             fill,
   input  logic [31:0]      pattern,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t state;
   logic [31:0] src_q, dst_q;
   logic [LEN_W-1:0] len_q, idx, idx_nx;
   logic desc_q, fill_q, fill_on, bad, desc_in, last;
   logic [31:0] fill_word;
   logic [32:0] src_end, dst_end;
`ifdef MOVER_FILL_EN
   assign fill_on = fill;
   assign fill_word = pattern;
`else
   // fill and pattern remain as ports only; every request is a copy
   assign fill_on = fill & 1'b0;
   assign fill_word = pattern & 32'd0;
`endif
   // 33-bit ends so a block running past the top of the address space is rejected, not wrapped
   assign src_end = {1'b0, src} + 33'(len);
   assign dst_end = {1'b0, dst} + 33'(len);
   assign bad = (!fill_on && src_end > 33'(RAM_SIZE)) || dst_end > 33'(RAM_SIZE);
   // destination overlapping the tail of the source: copy from the top down
   assign desc_in = !fill_on && dst > src && {1'b0, dst} < src_end;
   assign idx_nx = idx + LEN_W'(1);
   assign last = idx_nx == len_q;
   function automatic logic [31:0] off(input logic d, input logic [LEN_W-1:0] l, input logic [LEN_W-1:0] i);
      return d ? 32'(l) - 32'(i) - 32'd1 : 32'(i);
   endfunction
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         idx <= '0;
         desc_q <= 1'b0;
         fill_q <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  src_q <= src;
                  dst_q <= dst;
                  len_q <= len;
                  fill_q <= fill_on;
                  desc_q <= desc_in;
                  idx <= '0;
                  busy <= 1'b1;
                  if (bad || len == '0) begin
                     state <= DONE;
                     done <= 1'b1;
                     err <= bad;
                  end else if (fill_on) begin
                     state <= WRITE;
                     mem_wr <= 1'b1;
                     mem_addr <= dst;
                     mem_wdata <= fill_word;
                  end else begin
                     state <= READ;
                     mem_rd <= 1'b1;
                     mem_addr <= src + off(desc_in, len, LEN_W'(0));
                  end
               end
            READ: begin
               state <= WRITE;
               mem_rd <= 1'b0;
               mem_wr <= 1'b1;
               mem_addr <= dst_q + off(desc_q, len_q, idx);
               mem_wdata <= mem_rdata;
            end
            WRITE: begin
               idx <= idx_nx;
               if (last) begin
                  state <= DONE;
                  mem_wr <= 1'b0;
                  mem_addr <= '0;
                  mem_wdata <= '0;
                  done <= 1'b1;
               end else if (fill_q)
                  mem_addr <= dst_q + 32'(idx_nx);
               else begin
                  state <= READ;
                  mem_wr <= 1'b0;
                  mem_wdata <= '0;
                  mem_rd <= 1'b1;
                  mem_addr <= src_q + off(desc_q, len_q, idx_nx);
               end
            end
            DONE: begin
               state <= IDLE;
               busy <= 1'b0;
               done <= 1'b0;
               err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
endmodule
